// File: rtl/fft_input_buffer.sv
// rtl/fft_input_buffer.sv - ping-pong sample collector feeding the 8-point FFT core
// Serial complex samples fill one bank while the other is held on x_* for the core.
module fft_input_buffer #(
  parameter int DW = 16,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_R_i,
  input  logic [DW-1:0] s_I_i,
  output logic          s_ready_o,
  input  logic          flush_i,
  input  logic          fft_busy_i,
  input  logic          fft_valid_i,
  output logic          start_o,
  output logic [DW-1:0] x_0_R_o,
  output logic [DW-1:0] x_1_R_o,
  output logic [DW-1:0] x_2_R_o,
  output logic [DW-1:0] x_3_R_o,
  output logic [DW-1:0] x_4_R_o,
  output logic [DW-1:0] x_5_R_o,
  output logic [DW-1:0] x_6_R_o,
  output logic [DW-1:0] x_7_R_o,
  output logic [DW-1:0] x_0_I_o,
  output logic [DW-1:0] x_1_I_o,
  output logic [DW-1:0] x_2_I_o,
  output logic [DW-1:0] x_3_I_o,
  output logic [DW-1:0] x_4_I_o,
  output logic [DW-1:0] x_5_I_o,
  output logic [DW-1:0] x_6_I_o,
  output logic [DW-1:0] x_7_I_o,
  output logic [1:0]    frame_pend_o
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [DW-1:0] bank_r [2][N];
  logic [DW-1:0] bank_i [2][N];
  logic [1:0]    full;
  logic [1:0]    full_nx;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_idx;
  logic          accept;
  logic          launch_done;

  // A full write bank stalls upstream; flush drops any sample offered with it.
  assign s_ready_o    = !full[wr_bank];
  assign accept       = s_valid_i && s_ready_o && !flush_i;
  assign frame_pend_o = {1'b0, full[0]} + {1'b0, full[1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start_o     = 1'b0;
    launch_done = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank] && !fft_busy_i) begin
          state_nx = START;
        end
      end
      START: begin
        start_o  = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (fft_valid_i) begin
          launch_done = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Set and clear can never hit the same bank: set needs it empty, clear needs it full.
  always_comb begin
    full_nx = full;
    if (accept && (wr_idx == LAST_IDX)) begin
      full_nx[wr_bank] = 1'b1;
    end
    if (launch_done) begin
      full_nx[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_r[b][k] <= '0;
          bank_i[b][k] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      full <= full_nx;
      if (launch_done) begin
        rd_bank <= ~rd_bank;
      end
      if (flush_i) begin
        wr_idx <= '0;
      end else if (accept) begin
        bank_r[wr_bank][wr_idx] <= s_R_i;
        bank_i[wr_bank][wr_idx] <= s_I_i;
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  assign x_0_R_o = bank_r[rd_bank][0];
  assign x_1_R_o = bank_r[rd_bank][1];
  assign x_2_R_o = bank_r[rd_bank][2];
  assign x_3_R_o = bank_r[rd_bank][3];
  assign x_4_R_o = bank_r[rd_bank][4];
  assign x_5_R_o = bank_r[rd_bank][5];
  assign x_6_R_o = bank_r[rd_bank][6];
  assign x_7_R_o = bank_r[rd_bank][7];
  assign x_0_I_o = bank_i[rd_bank][0];
  assign x_1_I_o = bank_i[rd_bank][1];
  assign x_2_I_o = bank_i[rd_bank][2];
  assign x_3_I_o = bank_i[rd_bank][3];
  assign x_4_I_o = bank_i[rd_bank][4];
  assign x_5_I_o = bank_i[rd_bank][5];
  assign x_6_I_o = bank_i[rd_bank][6];
  assign x_7_I_o = bank_i[rd_bank][7];

endmodule

// File: doc/fft_input_buffer.md
Name: fft_input_buffer

Overview:
Upstream feeder for the 8-point radix-2 FFT core (fft_top). It collects a serial stream of complex Q8.8 samples through a valid/ready handshake into a ping-pong pair of 8-entry banks. When a bank is full and the core is idle, it presents that bank on the core's parallel x_k inputs and pulses start. The bank is held stable until the core's valid_o returns, while the other bank keeps filling.

Parameters:
DW, 16, sample width per real/imag component (signed Q8.8, two's complement)
N, 8, points per frame (fixed; must match fft_top)

Ports:
clk  input  1  clock; all state on posedge
rst  input  1  asynchronous reset, active-low (asserted when 0)
s_valid_i  input  1  upstream sample valid
s_R_i  input  DW  sample real part
s_I_i  input  DW  sample imaginary part
s_ready_o  output  1  buffer can accept a sample this cycle
flush_i  input  1  synchronous; discard the partially filled write bank
fft_busy_i  input  1  from fft_top busy_o
fft_valid_i  input  1  from fft_top valid_o (frame consumed)
start_o  output  1  to fft_top start_i, one-cycle pulse
x_0_R_o .. x_7_R_o  output  DW each  real parts of the launched frame, index k = arrival order
x_0_I_o .. x_7_I_o  output  DW each  imaginary parts of the launched frame
frame_pend_o  output  2  number of full banks (0..2)

Behaviour:
- Storage: bank[0..1][0..7] of {R,I}; full[1:0]; wr_bank, wr_idx[2:0], rd_bank.
- Reset (rst=0, async): all bank words 0, full=0, wr_bank=0, wr_idx=0, rd_bank=0, state=IDLE, start_o=0.
- After reset: s_ready_o=1, all x_* outputs 0, frame_pend_o=0.
- s_ready_o = !full[wr_bank], combinational from registered state only. It does not depend on s_valid_i or fft_valid_i.
- Accept: on a posedge with s_valid_i && s_ready_o:
  - Write {s_R_i, s_I_i} to bank[wr_bank][wr_idx] and increment wr_idx.
  - When wr_idx==7: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
- Samples are stored bit-exact; no arithmetic or saturation.
- flush_i:
  - Sets wr_idx=0; has no effect on full banks or the launch FSM.
  - If flush_i and an accept occur in the same cycle, flush wins and the sample is dropped.
  - A flush never un-fills a bank.
- x_k outputs = bank[rd_bank][k], muxed combinationally from registers.
- Launch FSM:
  - IDLE: if full[rd_bank] && !fft_busy_i -> START.
  - START: start_o=1 for exactly this cycle -> WAIT.
  - WAIT: on fft_valid_i, clear full[rd_bank], toggle rd_bank -> IDLE.
  - fft_valid_i in IDLE/START is ignored.
  - fft_busy_i high in IDLE holds IDLE indefinitely.
- Latency: with the FSM idle and the core idle, if the 8th sample is accepted at edge T, then start_o is high between edges T+1 and T+2.
- Back-to-back: the next launch occurs no earlier than 1 cycle after the fft_valid_i edge (via IDLE).
- Stability: while full[rd_bank]=1 the bank is not writable, so x_* are constant from START through the fft_valid_i edge.
- Simultaneous events:
  - fft_valid_i clearing a bank on the same edge a write would target it: that write is blocked because s_ready_o was 0.
  - Accept to the other bank plus fft_valid_i on the same edge: both take effect.
- Both banks full: s_ready_o=0 and upstream stalls; frame_pend_o=2.
- frame_pend_o = full[0]+full[1].
- Reset mid-operation (any state) returns everything to reset values immediately. Frames in flight are lost, and start_o drops asynchronously.

Test Plan:
- Reset then idle: rst=0 -> s_ready_o=1, start_o=0, all x_*=0x0000, frame_pend_o=0; same after rst=1 with no input.
- Single frame: stream (4,3),(8,9),(12,15),(12,16),(18,16),(14,12),(11,7),(5,2) in Q8.8, s_valid_i=1 every cycle, fft_busy_i=0 -> start_o pulses 1 cycle the edge after the 8th accept. x_0_R_o=0x0400, x_0_I_o=0x0300, x_7_R_o=0x0500, x_7_I_o=0x0200, constant until fft_valid_i.
- Ping-pong: second frame streamed during WAIT -> frame_pend_o=2, s_ready_o=0, 9th extra sample stalled. After fft_valid_i, x_* switch to frame 2 and start_o pulses exactly one cycle later.
- Busy gating: frame full with fft_busy_i=1 for 10 cycles -> no start_o; start_o pulses the cycle after fft_busy_i falls.
- Flush: accept 5 samples, flush_i=1 with s_valid_i=1 -> sample dropped, wr_idx=0. The next 8 samples form the frame, with x_0 equal to the first post-flush sample.
- Async reset in WAIT with the second bank half-filled -> all outputs to reset values without a clock edge. A fresh 8-sample frame afterwards launches normally.
